// File: rtl/branch_resolve_if.sv
// Request, flag and resolution signals between the branch unit and its pipeline neighbours.
// master drives requests/flags/stall; slave is the resolver.
interface branch_resolve_if #(
    parameter int unsigned AW = 16
);
    logic          br_valid;
    logic          br_ready;
    logic [3:0]    br_cond;
    logic [AW-1:0] br_target;
    logic          N;
    logic          C;
    logic          Z;
    logic          V;
    logic          stall;
    logic          resolve_valid;
    logic          taken;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          flush;
    logic [15:0]   taken_cnt;

    modport master (
        output br_valid, br_cond, br_target, N, C, Z, V, stall,
        input  br_ready, resolve_valid, taken, redirect_valid, redirect_pc, flush, taken_cnt
    );

    modport slave (
        input  br_valid, br_cond, br_target, N, C, Z, V, stall,
        output br_ready, resolve_valid, taken, redirect_valid, redirect_pc, flush, taken_cnt
    );
endinterface

// File: rtl/branch_resolve.sv
// Branch resolver: latches a conditional branch, evaluates it against live NZCV flags,
// and on a taken result redirects fetch and holds flush for FLUSH_CYCLES cycles.
module branch_resolve #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned AW           = 16
) (
    input logic             clk,
    input logic             rst,
    branch_resolve_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EVAL, FLUSH} state_t;

    state_t        state;
    logic [3:0]    cond_q;
    logic [AW-1:0] target_q;
    logic [3:0]    flush_cnt;
    logic          resolve_q;
    logic          taken_q;
    logic          redirect_q;
    logic [AW-1:0] redirect_pc_q;
    logic          flush_q;
    logic [15:0]   taken_cnt_q;
    logic          cond_hit;

    always_comb begin
        cond_hit = 1'b0;
        case (cond_q)
            4'h0: cond_hit = bus.Z;
            4'h1: cond_hit = !bus.Z;
            4'h2: cond_hit = bus.C;
            4'h3: cond_hit = !bus.C;
            4'h4: cond_hit = bus.N;
            4'h5: cond_hit = !bus.N;
            4'h6: cond_hit = bus.V;
            4'h7: cond_hit = !bus.V;
            4'h8: cond_hit = bus.C && !bus.Z;
            4'h9: cond_hit = !bus.C || bus.Z;
            4'hA: cond_hit = (bus.N == bus.V);
            4'hB: cond_hit = (bus.N != bus.V);
            4'hC: cond_hit = !bus.Z && (bus.N == bus.V);
            4'hD: cond_hit = bus.Z || (bus.N != bus.V);
            4'hE: cond_hit = 1'b1;
            default: cond_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cond_q        <= '0;
            target_q      <= '0;
            flush_cnt     <= '0;
            resolve_q     <= 1'b0;
            taken_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            flush_q       <= 1'b0;
            taken_cnt_q   <= '0;
        end else begin
            resolve_q  <= 1'b0;
            taken_q    <= 1'b0;
            redirect_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.br_valid) begin
                        cond_q   <= bus.br_cond;
                        target_q <= bus.br_target;
                        state    <= EVAL;
                    end
                end
                EVAL: begin
                    if (!bus.stall) begin
                        resolve_q <= 1'b1;
                        taken_q   <= cond_hit;
                        if (cond_hit) begin
                            redirect_q    <= 1'b1;
                            redirect_pc_q <= target_q;
                            flush_q       <= 1'b1;
                            // first flush cycle is this one, so count the remainder
                            flush_cnt     <= 4'(FLUSH_CYCLES - 1);
                            state         <= FLUSH;
                            if (taken_cnt_q != '1)
                                taken_cnt_q <= taken_cnt_q + 16'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        flush_q <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.br_ready       = (state == IDLE);
    assign bus.resolve_valid  = resolve_q;
    assign bus.taken          = taken_q;
    assign bus.redirect_valid = redirect_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush          = flush_q;
    assign bus.taken_cnt      = taken_cnt_q;
endmodule

// File: tb/tb_branch_resolve.sv
// Directed plus randomized bench for branch_resolve against a condition/timing reference model.
module tb_branch_resolve;
    localparam int unsigned AW           = 16;
    localparam int unsigned FLUSH_CYCLES = 2;

    logic clk;
    logic rst;
    int unsigned n_checks;
    int unsigned n_fail;
    logic [15:0]   model_cnt;
    logic [AW-1:0] model_pc;

    branch_resolve_if #(.AW(AW)) bus ();

    branch_resolve #(.FLUSH_CYCLES(FLUSH_CYCLES), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Conditions come in complementary pairs: odd codes invert the even predicate (AL/NV included).
    function automatic logic model_taken(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_flags(input logic [3:0] f);
        {bus.N, bus.Z, bus.C, bus.V} = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_branch(input logic [3:0] cond, input logic [AW-1:0] tgt,
                              input logic [3:0] f, input int unsigned stalls,
                              input bit valid_in_flush);
        logic exp;
        exp = model_taken(cond, f);
        chk("ready_before", 32'(bus.br_ready), 32'd1);
        bus.br_valid  = 1'b1;
        bus.br_cond   = cond;
        bus.br_target = tgt;
        set_flags(~f);
        tick();
        bus.br_valid  = 1'b0;
        bus.br_cond   = ~cond;
        bus.br_target = ~tgt;
        chk("accept_busy", 32'(bus.br_ready), 32'd0);
        chk("no_early_resolve", 32'(bus.resolve_valid), 32'd0);
        bus.stall = (stalls != 0);
        for (int unsigned i = 0; i < stalls; i++) begin
            tick();
            chk("stall_no_resolve", 32'(bus.resolve_valid), 32'd0);
            chk("stall_busy", 32'(bus.br_ready), 32'd0);
        end
        bus.stall = 1'b0;
        set_flags(f);
        tick();
        set_flags(~f);
        if (exp) begin
            model_pc = tgt;
            if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
        end
        chk("resolve_pulse", 32'(bus.resolve_valid), 32'd1);
        chk("taken", 32'(bus.taken), 32'(exp));
        chk("redirect_valid", 32'(bus.redirect_valid), 32'(exp));
        chk("flush_first", 32'(bus.flush), 32'(exp));
        chk("ready_resolve", 32'(bus.br_ready), 32'(!exp));
        chk("redirect_pc", 32'(bus.redirect_pc), 32'(model_pc));
        chk("taken_cnt", 32'(bus.taken_cnt), 32'(model_cnt));
        if (exp) begin
            bus.br_valid = valid_in_flush;
            for (int unsigned i = 1; i < FLUSH_CYCLES; i++) begin
                bus.stall = 1'($urandom_range(0, 1));
                tick();
                chk("flush_hold", 32'(bus.flush), 32'd1);
                chk("flush_no_resolve", 32'(bus.resolve_valid), 32'd0);
                chk("flush_no_redirect", 32'(bus.redirect_valid), 32'd0);
                chk("flush_busy", 32'(bus.br_ready), 32'd0);
                chk("pc_hold", 32'(bus.redirect_pc), 32'(model_pc));
            end
            bus.stall = 1'($urandom_range(0, 1));
            tick();
            bus.br_valid = 1'b0;
            bus.stall    = 1'b0;
            chk("flush_end", 32'(bus.flush), 32'd0);
            chk("ready_after_flush", 32'(bus.br_ready), 32'd1);
            chk("post_flush_no_resolve", 32'(bus.resolve_valid), 32'd0);
        end else begin
            tick();
            chk("nt_pulse_end", 32'(bus.resolve_valid), 32'd0);
            chk("nt_taken_low", 32'(bus.taken), 32'd0);
            chk("nt_ready", 32'(bus.br_ready), 32'd1);
            chk("nt_flush_low", 32'(bus.flush), 32'd0);
            chk("nt_pc_hold", 32'(bus.redirect_pc), 32'(model_pc));
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        model_cnt     = '0;
        model_pc      = '0;
        rst           = 1'b1;
        bus.br_valid  = 1'b0;
        bus.br_cond   = '0;
        bus.br_target = '0;
        bus.stall     = 1'b0;
        set_flags(4'b0000);
        tick();
        tick();
        chk("rst_resolve", 32'(bus.resolve_valid), 32'd0);
        chk("rst_taken", 32'(bus.taken), 32'd0);
        chk("rst_redirect", 32'(bus.redirect_valid), 32'd0);
        chk("rst_pc", 32'(bus.redirect_pc), 32'd0);
        chk("rst_flush", 32'(bus.flush), 32'd0);
        chk("rst_cnt", 32'(bus.taken_cnt), 32'd0);
        chk("rst_ready", 32'(bus.br_ready), 32'd1);
        rst = 1'b0;

        // EQ taken, then LT not taken with N=V
        run_branch(4'h0, 16'h1234, 4'b0100, 0, 1'b0);
        run_branch(4'hB, 16'h5678, 4'b1001, 0, 1'b0);
        // stalled evaluation: inverted flags during stall must be ignored
        run_branch(4'h0, 16'hBEEF, 4'b0100, 3, 1'b0);
        run_branch(4'h1, 16'h0F0F, 4'b0100, 3, 1'b0);

        for (int unsigned c = 0; c < 16; c++) begin
            for (int unsigned f = 0; f < 16; f++) begin
                run_branch(4'(c), 16'($urandom), 4'(f), $urandom_range(0, 2), 1'b0);
            end
        end

        // br_valid held through flush must not be queued
        run_branch(4'hE, 16'hA5A5, 4'b0000, 0, 1'b1);
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            chk("ignored_req_no_resolve", 32'(bus.resolve_valid), 32'd0);
            chk("ignored_req_ready", 32'(bus.br_ready), 32'd1);
        end

        // saturation from a preloaded count
        force dut.taken_cnt_q = 16'hFFFE;
        #1;
        release dut.taken_cnt_q;
        model_cnt = 16'hFFFE;
        chk("preload_cnt", 32'(bus.taken_cnt), 32'hFFFE);
        for (int unsigned i = 0; i < 3; i++) begin
            run_branch(4'hE, 16'(16'h4000 + i), 4'($urandom), 0, 1'b0);
        end
        chk("sat_cnt", 32'(bus.taken_cnt), 32'hFFFF);

        // reset during flush
        bus.br_valid  = 1'b1;
        bus.br_cond   = 4'hE;
        bus.br_target = 16'h7777;
        tick();
        bus.br_valid = 1'b0;
        tick();
        chk("pre_rst_flush", 32'(bus.flush), 32'd1);
        rst = 1'b1;
        #1;
        model_cnt = '0;
        model_pc  = '0;
        chk("rst_mid_flush", 32'(bus.flush), 32'd0);
        chk("rst_mid_ready", 32'(bus.br_ready), 32'd1);
        chk("rst_mid_redirect", 32'(bus.redirect_valid), 32'd0);
        chk("rst_mid_resolve", 32'(bus.resolve_valid), 32'd0);
        chk("rst_mid_cnt", 32'(bus.taken_cnt), 32'd0);
        chk("rst_mid_pc", 32'(bus.redirect_pc), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        // acceptance on the first edge after release
        run_branch(4'hC, 16'h2468, 4'b0000, 0, 1'b0);
        for (int unsigned i = 0; i < 2; i++) begin
            tick();
            chk("idle_no_pulse", 32'(bus.resolve_valid | bus.redirect_valid | bus.flush), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
